// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the MEM stage
// and the burst DMA/loader port.
package dm_arbiter_pkg;
  localparam int DM_AW = 10;
  localparam int DM_DW = 32;

  localparam logic DMA_DIR_RD = 1'b0;
  localparam logic DMA_DIR_WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } dm_state_e;
endpackage

// File: rtl/dm_be_merge.sv
// Byte-lane merge: each lane takes the new byte when its enable is set,
// otherwise keeps the byte currently stored in the word.
module dm_be_merge
  import dm_arbiter_pkg::*;
(
  input  logic [DM_DW/8-1:0] be,
  input  logic [DM_DW-1:0]   new_word,
  input  logic [DM_DW-1:0]   old_word,
  output logic [DM_DW-1:0]   merged
);
  for (genvar i = 0; i < DM_DW/8; i++) begin : g_lane
    assign merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end
endmodule

// File: rtl/dm_arbiter.sv
// Single-port data-memory arbiter: CPU has zero-latency priority, DMA bursts
// use idle cycles and a starvation counter steals one CPU cycle when needed.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int LEN_W    = 8
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [DM_AW-1:0] cpu_addr,
  input  logic [3:0]       cpu_be,
  input  logic [DM_DW-1:0] cpu_wdata,
  output logic [DM_DW-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_start,
  input  logic             dma_dir,
  input  logic [DM_AW-1:0] dma_base,
  input  logic [LEN_W-1:0] dma_len,
  input  logic [DM_DW-1:0] dma_wdata,
  input  logic             dma_wvalid,
  output logic             dma_wready,
  output logic [DM_DW-1:0] dma_rdata,
  output logic             dma_rvalid,
  input  logic             dma_rready,
  output logic             dma_busy,
  output logic             dma_done,
  output logic [DM_AW-1:0] mem_addr,
  output logic [DM_DW-1:0] mem_din,
  output logic             mem_we,
  input  logic [DM_DW-1:0] mem_dout
);
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  dm_state_e        state;
  logic             dir;
  logic [DM_AW-1:0] ptr;
  logic [LEN_W-1:0] remain;
  logic [7:0]       wait_cnt;
  logic             pending, forced, cpu_own, dma_grant;
  logic [DM_DW-1:0] cpu_merged;

  // A read beat only competes when the holding register is free or being drained.
  assign pending   = !rst && (state == ST_BUSY) && (remain != '0) &&
                     ((dir == DMA_DIR_WR) ? dma_wvalid : (!dma_rvalid || dma_rready));
  assign forced    = pending && (wait_cnt == WAIT_MAX);
  assign cpu_own   = cpu_req && !forced;
  assign dma_grant = pending && !cpu_own;

  assign cpu_stall  = cpu_req && forced;
  assign cpu_rdata  = mem_dout;
  assign dma_wready = dma_grant && (dir == DMA_DIR_WR);

  dm_be_merge u_merge (
    .be       (cpu_be),
    .new_word (cpu_wdata),
    .old_word (mem_dout),
    .merged   (cpu_merged)
  );

  // Idle cycles keep the CPU address on the bus so cpu_rdata stays meaningful.
  always_comb begin
    mem_addr = cpu_addr;
    mem_din  = cpu_merged;
    mem_we   = 1'b0;
    if (rst) begin
      mem_we = 1'b0;
    end else if (cpu_own) begin
      mem_we = cpu_we && (|cpu_be);
    end else if (dma_grant) begin
      mem_addr = ptr;
      mem_din  = dma_wdata;
      mem_we   = (dir == DMA_DIR_WR);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      dir        <= DMA_DIR_RD;
      ptr        <= '0;
      remain     <= '0;
      wait_cnt   <= '0;
      dma_busy   <= 1'b0;
      dma_done   <= 1'b0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dma_start) begin
            ptr    <= dma_base;
            remain <= dma_len;
            dir    <= dma_dir;
            if (dma_len == '0) begin
              state    <= ST_DONE;
              dma_done <= 1'b1;
            end else begin
              state    <= ST_BUSY;
              dma_busy <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (dma_grant) begin
            ptr    <= ptr + 1'b1;
            remain <= remain - 1'b1;
            if (remain == LEN_W'(1)) begin
              state    <= ST_DONE;
              dma_busy <= 1'b0;
              dma_done <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state    <= ST_IDLE;
          dma_busy <= 1'b0;
        end
      endcase

      // Counts only cycles where a ready beat lost to the CPU.
      if (state != ST_BUSY || dma_grant)
        wait_cnt <= '0;
      else if (pending && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 8'd1;

      if (dma_grant && dir == DMA_DIR_RD) begin
        dma_rvalid <= 1'b1;
        dma_rdata  <= mem_dout;
      end else if (dma_rready) begin
        dma_rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: behavioural 1024x32 memory, reference image of memory
// contents, and a queue of expected read beats/loads.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int LEN_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cpu_req = 1'b0, cpu_we = 1'b0;
  logic [9:0]       cpu_addr = '0;
  logic [3:0]       cpu_be = '0;
  logic [31:0]      cpu_wdata = '0, cpu_rdata;
  logic             cpu_stall;
  logic             dma_start = 1'b0, dma_dir = 1'b0;
  logic [9:0]       dma_base = '0;
  logic [LEN_W-1:0] dma_len = '0;
  logic [31:0]      dma_wdata = '0, dma_rdata;
  logic             dma_wvalid = 1'b0, dma_wready, dma_rvalid;
  logic             dma_rready = 1'b1, dma_busy, dma_done;
  logic [9:0]       mem_addr;
  logic [31:0]      mem_din, mem_dout;
  logic             mem_we;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] exp_q   [$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  dm_arbiter #(.MAX_WAIT(MAX_WAIT), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_start(dma_start), .dma_dir(dma_dir), .dma_base(dma_base), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_wvalid(dma_wvalid), .dma_wready(dma_wready),
    .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_rready(dma_rready),
    .dma_busy(dma_busy), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input int a, input logic [3:0] be, input logic [31:0] d, input bit check);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'(a); cpu_be = be; cpu_wdata = d;
    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    @(negedge clk);
    if (check) begin
      chk("cpu_wr_stall", 32'(cpu_stall), 0);
      chk("cpu_wr_we", 32'(mem_we), 32'(|be));
      if (|be) chk("cpu_wr_din", mem_din, ref_mem[a]);
    end
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input int a, input logic [31:0] exp, input string tag);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'(a);
    exp_q.push_back(exp);
    @(negedge clk);
    chk(tag, cpu_rdata, exp_q.pop_front());
    chk("cpu_rd_stall", 32'(cpu_stall), 0);
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic dma_wr(input int base, input int len, input bit hog, input int abort_at,
                        input bit poke, input logic [31:0] dbase);
    int beats, cyc, wait_run, first, last;
    bit fin;
    beats = 0; cyc = 0; wait_run = 0; first = -1; last = -1; fin = 1'b0;
    dma_dir = DMA_DIR_WR; dma_base = 10'(base); dma_len = LEN_W'(len); dma_start = 1'b1;
    dma_wvalid = 1'b0;
    tick();
    dma_start = 1'b0; dma_wvalid = 1'b1; dma_wdata = dbase + 32'd1;
    cpu_req = hog; cpu_we = 1'b0; cpu_addr = 10'd7;
    while (!fin && cyc < 200) begin
      if (poke && cyc == 1) begin
        dma_start = 1'b1; dma_base = 10'd500; dma_len = LEN_W'(9); dma_dir = DMA_DIR_RD;
      end
      @(negedge clk);
      if (dma_wready) begin
        chk("wr_addr", 32'(mem_addr), 32'((base + beats) % 1024));
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_din", mem_din, dbase + 32'(beats) + 32'd1);
        if (hog) begin
          chk("hog_wait", 32'(wait_run), MAX_WAIT);
          chk("hog_stall", 32'(cpu_stall), 1);
        end
        ref_mem[(base + beats) % 1024] = dbase + 32'(beats) + 32'd1;
        beats++; wait_run = 0;
        if (first < 0) first = cyc;
        last = cyc;
      end else if (hog && beats < len) begin
        chk("hog_cpu_won", 32'(cpu_stall), 0);
        chk("hog_rdata", cpu_rdata, ref_mem[7]);
        wait_run++;
      end
      if (dma_done) begin
        chk("wr_done_lat", 32'(cyc), 32'(last + 1));
        chk("wr_beats", 32'(beats), 32'(len));
        chk("wr_done_busy", 32'(dma_busy), 0);
        fin = 1'b1;
      end
      if (abort_at > 0 && beats == abort_at) fin = 1'b1;
      tick();
      dma_start = 1'b0; dma_dir = DMA_DIR_WR; dma_base = 10'(base);
      dma_wdata = dbase + 32'(beats) + 32'd1;
      cyc++;
    end
    if (!fin) chk("wr_timeout", 0, 1);
    if (abort_at == 0) begin
      dma_wvalid = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      chk("wr_done_1cyc", 32'(dma_done), 0);
      tick();
      if (!hog) begin
        chk("wr_first", 32'(first), 0);
        chk("wr_consec", 32'(last - first), 32'(len - 1));
      end
    end
  endtask

  task automatic dma_rd(input int base, input int len, input int hold);
    int got, cyc, held;
    bit done_seen;
    for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[(base + i) % 1024]);
    dma_dir = DMA_DIR_RD; dma_base = 10'(base); dma_len = LEN_W'(len);
    dma_start = 1'b1; dma_rready = (hold == 0);
    tick();
    dma_start = 1'b0;
    got = 0; cyc = 0; held = 0; done_seen = 1'b0;
    while (!(done_seen && got == len) && cyc < 200) begin
      @(negedge clk);
      if (dma_rvalid && dma_rready) begin
        if (exp_q.size() == 0) chk("rd_extra_beat", 1, 0);
        else chk($sformatf("rd_beat%0d", got), dma_rdata, exp_q.pop_front());
        got++;
      end
      if (dma_rvalid && !dma_rready) held++;
      if (dma_done) begin
        chk("rd_done_cnt", 32'(got + ((dma_rvalid && !dma_rready) ? 1 : 0)), 32'(len));
        done_seen = 1'b1;
      end
      tick();
      if (held >= hold) dma_rready = 1'b1;
      cyc++;
    end
    chk("rd_total", 32'(got), 32'(len));
    chk("rd_held", 32'(held), 32'(hold));
    chk("rd_q_empty", 32'(exp_q.size()), 0);
    @(negedge clk);
    chk("rd_rvalid_clr", 32'(dma_rvalid), 0);
    tick();
  endtask

  initial begin
    // Reset: CPU store attempted during reset must not write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_busy", 32'(dma_busy), 0);
    chk("rst_done", 32'(dma_done), 0);
    chk("rst_rvalid", 32'(dma_rvalid), 0);
    chk("rst_rdata", dma_rdata, 0);
    tick();
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;

    for (int i = 0; i < 1024; i++)
      cpu_write(i, 4'hF, 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000, 1'b0);

    // Sub-word store merge
    cpu_write(5, 4'hF, 32'h11223344, 1'b1);
    cpu_write(5, 4'b0100, 32'h00AB0000, 1'b1);
    cpu_read(5, 32'h11AB3344, "sb_merge");
    cpu_write(6, 4'h0, 32'hFFFFFFFF, 1'b1);
    cpu_read(6, ref_mem[6], "be0_nowrite");
    cpu_write(8, 4'b1001, 32'hAA0000BB, 1'b1);
    cpu_read(8, ref_mem[8], "be1001_merge");

    // Plain write burst, CPU idle
    dma_wr(10, 3, 1'b0, 0, 1'b0, 32'h0);
    cpu_read(10, 32'd1, "wr_word10");
    cpu_read(11, 32'd2, "wr_word11");
    cpu_read(12, 32'd3, "wr_word12");
    cpu_read(13, ref_mem[13], "wr_word13_keep");

    // Read burst wrapping past 1023 with consumer back-pressure
    dma_rd(1022, 3, 2);

    // CPU hogging the port: forced grant every MAX_WAIT+1 cycles
    dma_wr(100, 2, 1'b1, 0, 1'b0, 32'hC0DE0000);
    cpu_read(100, 32'hC0DE0001, "hog_word100");
    cpu_read(101, 32'hC0DE0002, "hog_word101");

    // Abort after 2 of 5 beats
    dma_wr(200, 5, 1'b0, 2, 1'b0, 32'hAB000000);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we", 32'(mem_we), 0);
    chk("abort_wready", 32'(dma_wready), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_busy", 32'(dma_busy), 0);
      chk("abort_done", 32'(dma_done), 0);
      chk("abort_wready_idle", 32'(dma_wready), 0);
      tick();
    end
    dma_wvalid = 1'b0;
    for (int i = 200; i < 205; i++) cpu_read(i, ref_mem[i], "abort_mem");
    cpu_read(201, 32'hAB000002, "abort_word201");

    // New start accepted after abort; a second start mid-burst is ignored
    dma_wr(300, 2, 1'b0, 0, 1'b1, 32'h77770000);
    cpu_read(300, 32'h77770001, "poke_word300");
    cpu_read(301, 32'h77770002, "poke_word301");
    cpu_read(500, ref_mem[500], "poke_word500");

    // Zero-length burst
    dma_dir = DMA_DIR_WR; dma_base = 10'd50; dma_len = '0; dma_start = 1'b1; dma_wvalid = 1'b1;
    @(negedge clk);
    chk("zero_we_start", 32'(mem_we), 0);
    tick();
    dma_start = 1'b0;
    @(negedge clk);
    chk("zero_done", 32'(dma_done), 1);
    chk("zero_we", 32'(mem_we), 0);
    chk("zero_wready", 32'(dma_wready), 0);
    chk("zero_busy", 32'(dma_busy), 0);
    tick();
    @(negedge clk);
    chk("zero_done_1cyc", 32'(dma_done), 0);
    tick();
    dma_wvalid = 1'b0;
    cpu_read(50, ref_mem[50], "zero_word50");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
